result_flags_register: RTL and testbench

Architectural result-flags register for cpu32e2. It consumes the registered `resultFlagsControl` class produced by the controller's EXECUTE0 flags decode, plus ALU, shifter and multiplier status. From these it updates the N/Z/O/C flags and holds off the controller while a multi-cycle multiply completes. It also provides the shadow copy used on interrupt entry and return, and the software flag-write path.

---
 rtl/result_flags_register_if.sv | 57 +++++
 rtl/result_flags_register.sv | 109 ++++++++++
 tb/tb_result_flags_register.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/result_flags_register_if.sv
// Control class package and flag-register bus for cpu32e2.
// Member names follow the controller/datapath signal names.
package resultFlagsGroup;
  typedef enum logic [2:0] {
    NO_OP,
    LOAD_ARITH,
    LOAD_ARITH_O,
    LOAD_LOGIC,
    LOAD_MULT,
    LOAD_SHIFT
  } controlBus;
endpackage

interface result_flags_register_if #(
  parameter int DATA_WIDTH = 32
);
  import resultFlagsGroup::*;

  logic                    enable;
  controlBus               resultFlagsControl;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_carry;
  logic                    alu_overflow;
  logic [DATA_WIDTH-1:0]   shift_result;
  logic                    shift_carry;
  logic                    shift_zero_count;
  logic [2*DATA_WIDTH-1:0] mult_result;
  logic                    mult_overflow;
  logic                    mult_valid;
  logic                    flags_save;
  logic                    flags_restore;
  logic                    flags_write;
  logic [3:0]              flags_wdata;
  logic [3:0]              flags;
  logic [3:0]              shadow_flags;
  logic                    busy;

  modport master (
    output enable, resultFlagsControl,
    output alu_result, alu_carry, alu_overflow,
    output shift_result, shift_carry, shift_zero_count,
    output mult_result, mult_overflow, mult_valid,
    output flags_save, flags_restore,
    output flags_write, flags_wdata,
    input  flags, shadow_flags, busy
  );

  modport slave (
    input  enable, resultFlagsControl,
    input  alu_result, alu_carry, alu_overflow,
    input  shift_result, shift_carry, shift_zero_count,
    input  mult_result, mult_overflow, mult_valid,
    input  flags_save, flags_restore,
    input  flags_write, flags_wdata,
    output flags, shadow_flags, busy
  );
endinterface

// File: rtl/result_flags_register.sv
// Architectural N/Z/O/C flags with multiply wait,
// interrupt shadow copy and software write path.
module result_flags_register
  import resultFlagsGroup::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  result_flags_register_if.slave bus
);

  typedef enum logic {
    IDLE,
    WAIT_MULT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] cls_flags;

  logic alu_z, alu_n;
  logic sh_z, sh_n;
  logic mu_z, mu_n;
  logic accept, mult_go, mult_cap;
  logic in_wait;

  assign alu_z = ~|bus.alu_result;
  assign alu_n = bus.alu_result[DATA_WIDTH-1];
  assign sh_z  = ~|bus.shift_result;
  assign sh_n  = bus.shift_result[DATA_WIDTH-1];
  assign mu_z  = ~|bus.mult_result;
  assign mu_n  = bus.mult_result[2*DATA_WIDTH-1];

  assign in_wait = (state_q == WAIT_MULT);
  assign accept  = bus.enable & ~in_wait
                 & (bus.resultFlagsControl != NO_OP);
  assign mult_go = accept
                 & (bus.resultFlagsControl == LOAD_MULT);
  // A product either completes a pending wait or
  // lands in the same cycle the class is accepted.
  assign mult_cap = bus.mult_valid & (in_wait | mult_go);

  always_comb begin
    cls_flags = flags_q;
    unique case (1'b1)
      (bus.resultFlagsControl == LOAD_ARITH):
        cls_flags = {alu_n, alu_z,
                     flags_q[1], bus.alu_carry};
      (bus.resultFlagsControl == LOAD_ARITH_O):
        cls_flags = {alu_n, alu_z,
                     bus.alu_overflow, bus.alu_carry};
      (bus.resultFlagsControl == LOAD_LOGIC):
        cls_flags = {alu_n, alu_z, 2'b00};
      (bus.resultFlagsControl == LOAD_SHIFT):
        if (!bus.shift_zero_count)
          cls_flags = {sh_n, sh_z,
                       flags_q[1], bus.shift_carry};
      default: cls_flags = flags_q;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (bus.flags_restore)
      flags_d = shadow_q;
    else if (bus.flags_write)
      flags_d = bus.flags_wdata;
    else if (mult_cap)
      flags_d = {mu_n, mu_z,
                 bus.mult_overflow, bus.mult_overflow};
    else if (accept && !mult_go)
      flags_d = cls_flags;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (bus.flags_save)
      shadow_d = flags_q;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flags_restore || bus.flags_write)
      state_d = IDLE;
    else if (in_wait && bus.mult_valid)
      state_d = IDLE;
    else if (mult_go && !bus.mult_valid)
      state_d = WAIT_MULT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      flags_q  <= 4'b0000;
      shadow_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.flags        = flags_q;
  assign bus.shadow_flags = shadow_q;
  assign bus.busy         = in_wait;

endmodule

// File: tb/tb_result_flags_register.sv
// Directed bench for result_flags_register.
// Inputs change 1ns after posedge; outputs checked there.
module tb_result_flags_register;
  import resultFlagsGroup::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  result_flags_register_if #(.DATA_WIDTH(32)) bus ();

  result_flags_register #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.enable             = 1'b1;
    bus.resultFlagsControl = NO_OP;
    bus.alu_result         = '0;
    bus.alu_carry          = 1'b0;
    bus.alu_overflow       = 1'b0;
    bus.shift_result       = '0;
    bus.shift_carry        = 1'b0;
    bus.shift_zero_count   = 1'b0;
    bus.mult_result        = '0;
    bus.mult_overflow      = 1'b0;
    bus.mult_valid         = 1'b0;
    bus.flags_save         = 1'b0;
    bus.flags_restore      = 1'b0;
    bus.flags_write        = 1'b0;
    bus.flags_wdata        = 4'b0000;
  endtask

  initial begin
    // reset with every input active
    reset                  = 1'b0;
    bus.enable             = 1'b1;
    bus.resultFlagsControl = LOAD_ARITH_O;
    bus.alu_result         = 32'h8000_0000;
    bus.alu_carry          = 1'b1;
    bus.alu_overflow       = 1'b1;
    bus.shift_result       = 32'hFFFF_FFFF;
    bus.shift_carry        = 1'b1;
    bus.shift_zero_count   = 1'b0;
    bus.mult_result        = 64'hFFFF_0000_0000_0000;
    bus.mult_overflow      = 1'b1;
    bus.mult_valid         = 1'b1;
    bus.flags_save         = 1'b1;
    bus.flags_restore      = 1'b1;
    bus.flags_write        = 1'b1;
    bus.flags_wdata        = 4'b1111;
    tick();
    tick();
    chk("rst_flags", bus.flags, 4'b0000);
    chk("rst_shadow", bus.shadow_flags, 4'b0000);
    chk("rst_busy", {3'b0, bus.busy}, 4'b0000);

    reset = 1'b1;
    idle_inputs();
    tick();
    chk("idle_flags", bus.flags, 4'b0000);

    bus.resultFlagsControl = LOAD_ARITH_O;
    bus.alu_result         = 32'h8000_0000;
    bus.alu_carry          = 1'b0;
    bus.alu_overflow       = 1'b1;
    tick();
    chk("add_ovf", bus.flags, 4'b1010);

    bus.resultFlagsControl = LOAD_ARITH;
    bus.alu_result         = 32'h0;
    bus.alu_carry          = 1'b1;
    bus.alu_overflow       = 1'b0;
    tick();
    chk("arith_o_hold", bus.flags, 4'b0111);

    idle_inputs();
    bus.flags_write = 1'b1;
    bus.flags_wdata = 4'b1111;
    tick();
    chk("write_1111", bus.flags, 4'b1111);

    idle_inputs();
    bus.resultFlagsControl = LOAD_LOGIC;
    bus.alu_result         = 32'h0000_0001;
    tick();
    chk("logic", bus.flags, 4'b0000);

    idle_inputs();
    bus.resultFlagsControl = LOAD_SHIFT;
    bus.shift_zero_count   = 1'b1;
    bus.shift_carry        = 1'b1;
    bus.shift_result       = 32'h0;
    tick();
    chk("shift_zc", bus.flags, 4'b0000);

    bus.shift_zero_count = 1'b0;
    tick();
    chk("shift", bus.flags, 4'b0101);

    // multiply with product three cycles later
    idle_inputs();
    bus.resultFlagsControl = LOAD_MULT;
    tick();
    chk("mul_busy0", {3'b0, bus.busy}, 4'b0001);
    chk("mul_hold", bus.flags, 4'b0101);
    bus.resultFlagsControl = LOAD_LOGIC;
    bus.alu_result         = 32'h0;
    tick();
    chk("mul_busy1", {3'b0, bus.busy}, 4'b0001);
    chk("mul_ignore", bus.flags, 4'b0101);
    tick();
    chk("mul_busy2", {3'b0, bus.busy}, 4'b0001);
    bus.resultFlagsControl = NO_OP;
    bus.mult_valid         = 1'b1;
    bus.mult_result        = 64'h0000_0001_0000_0000;
    bus.mult_overflow      = 1'b1;
    tick();
    chk("mul_done_busy", {3'b0, bus.busy}, 4'b0000);
    chk("mul_flags", bus.flags, 4'b0011);

    // product in the same cycle as the class
    idle_inputs();
    bus.resultFlagsControl = LOAD_MULT;
    bus.mult_valid         = 1'b1;
    bus.mult_result        = 64'h8000_0000_0000_0000;
    bus.mult_overflow      = 1'b0;
    tick();
    chk("mul_fast_busy", {3'b0, bus.busy}, 4'b0000);
    chk("mul_fast", bus.flags, 4'b1000);

    idle_inputs();
    bus.mult_valid    = 1'b1;
    bus.mult_overflow = 1'b1;
    tick();
    chk("stray_mv", bus.flags, 4'b1000);
    chk("stray_busy", {3'b0, bus.busy}, 4'b0000);

    // stall with held class
    idle_inputs();
    bus.enable             = 1'b0;
    bus.resultFlagsControl = LOAD_LOGIC;
    bus.alu_result         = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall", bus.flags, 4'b1000);
    end
    bus.enable = 1'b1;
    tick();
    chk("stall_go", bus.flags, 4'b0100);
    bus.resultFlagsControl = NO_OP;
    bus.alu_result         = 32'h8000_0000;
    tick();
    chk("stall_once", bus.flags, 4'b0100);

    // shadow save / swap / restore
    idle_inputs();
    bus.flags_write = 1'b1;
    bus.flags_wdata = 4'b1010;
    tick();
    idle_inputs();
    bus.resultFlagsControl = LOAD_LOGIC;
    bus.alu_result         = 32'h0000_0001;
    bus.flags_save         = 1'b1;
    tick();
    chk("save_shadow", bus.shadow_flags, 4'b1010);
    chk("save_flags", bus.flags, 4'b0000);

    idle_inputs();
    bus.flags_save    = 1'b1;
    bus.flags_restore = 1'b1;
    tick();
    chk("swap_flags", bus.flags, 4'b1010);
    chk("swap_shadow", bus.shadow_flags, 4'b0000);

    idle_inputs();
    bus.flags_restore = 1'b1;
    bus.flags_write   = 1'b1;
    bus.flags_wdata   = 4'b1111;
    tick();
    chk("restore_prio", bus.flags, 4'b0000);

    // software write abandons a pending multiply
    idle_inputs();
    bus.resultFlagsControl = LOAD_MULT;
    tick();
    chk("wr_busy", {3'b0, bus.busy}, 4'b0001);
    idle_inputs();
    bus.flags_write = 1'b1;
    bus.flags_wdata = 4'b0110;
    tick();
    chk("wr_flags", bus.flags, 4'b0110);
    chk("wr_busy_fall", {3'b0, bus.busy}, 4'b0000);
    idle_inputs();
    bus.mult_valid    = 1'b1;
    bus.mult_overflow = 1'b1;
    bus.mult_result   = 64'h8000_0000_0000_0000;
    tick();
    chk("wr_late_mv", bus.flags, 4'b0110);

    // reset during wait
    idle_inputs();
    bus.resultFlagsControl = LOAD_MULT;
    tick();
    chk("rw_busy", {3'b0, bus.busy}, 4'b0001);
    reset = 1'b0;
    tick();
    chk("rw_busy_fall", {3'b0, bus.busy}, 4'b0000);
    chk("rw_flags", bus.flags, 4'b0000);
    reset = 1'b1;
    idle_inputs();
    bus.mult_valid    = 1'b1;
    bus.mult_overflow = 1'b1;
    bus.mult_result   = 64'h8000_0000_0000_0000;
    tick();
    chk("rw_late_mv", bus.flags, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
